pll_div_model: RTL and testbench

//  Parametrised, synthesizable successor to the single-output PLL sim stub: derives NUM_CH divided clocks
//  (registered level outputs + 1-cycle enable strobes) from one reference clock, with runtime divide/phase
//  per channel and a lock sequencer. Sits between board clock input and the design's clock-domain consumers.

---
 rtl/pll_div_pkg.sv | 17 +
 rtl/pll_div_model_if.sv | 25 ++
 rtl/pll_div_chan.sv | 84 ++++++++
 rtl/pll_div_model.sv | 98 +++++++++
 tb/tb_pll_div_model.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pll_div_pkg.sv
// Shared types and helpers for the multi-channel PLL divider model.
package pll_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int DEF_DIV_W = 8;

  // Counter must be able to hold LOCK_CYCLES itself, since it saturates there.
  function automatic int lock_cnt_w(input int lock_cycles);
    return (lock_cycles < 1) ? 1 : $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/pll_div_model_if.sv
// Control/status bundle of pll_div_model: run/config inputs and divided clock outputs.
interface pll_div_model_if
  import pll_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DEF_DIV_W
);
  logic                    en;
  logic                    cfg_load;
  logic [NUM_CH*DIV_W-1:0] cfg_div;
  logic [NUM_CH*DIV_W-1:0] cfg_phase;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_en;
  logic                    locked;

  modport master (
    output en, cfg_load, cfg_div, cfg_phase,
    input  clk_out, clk_en, locked
  );

  modport slave (
    input  en, cfg_load, cfg_div, cfg_phase,
    output clk_out, clk_en, locked
  );
endinterface

// File: rtl/pll_div_chan.sv
// One divider channel: captured divide/phase, wrap counter, registered level and strobe.
// Phase offset is only built when PLL_DIV_PHASE_EN is defined.
module pll_div_chan
  import pll_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_load,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [DIV_W-1:0] i_cfg_phase,
  input  logic             i_start,
  input  logic             i_run,
  input  logic             i_clear,
  output logic             o_clk_out,
  output logic             o_clk_en
);

  localparam logic [DIV_W-1:0] ONE   = 1;
  localparam logic [DIV_W:0]   ONE_W = 1;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_clk_en;
  logic [DIV_W-1:0] w_div_eff;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W:0]   w_half;
  logic [DIV_W-1:0] w_start_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic             w_active;

  assign w_div_eff = (r_div == '0) ? ONE : r_div;
  assign w_last    = w_div_eff - ONE;
  assign w_half    = ({1'b0, w_div_eff} + ONE_W) >> 1;

`ifdef PLL_DIV_PHASE_EN
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] w_phase_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_phase <= '0;
    else if (i_cfg_load) r_phase <= i_cfg_phase;
  end

  assign w_phase_eff = (r_phase > w_last) ? w_last : r_phase;
  assign w_start_cnt = (w_phase_eff == '0) ? '0 : (w_div_eff - w_phase_eff);
`else
  logic w_unused_phase;
  assign w_unused_phase = ^i_cfg_phase;
  assign w_start_cnt    = '0;
`endif

  assign w_active = (i_start || i_run) && !i_clear;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear)      w_cnt_next = '0;
    else if (i_start) w_cnt_next = w_start_cnt;
    else if (i_run)   w_cnt_next = (r_cnt >= w_last) ? '0 : (r_cnt + ONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: captured cfg is reset too, so an async reset restores divide-by-1 on every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= ONE;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_clk_en  <= 1'b0;
    end else begin
      if (i_cfg_load) r_div <= i_cfg_div;
      r_cnt     <= w_cnt_next;
      r_clk_out <= w_active && ({1'b0, w_cnt_next} < w_half);
      r_clk_en  <= w_active && (w_cnt_next == '0);
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_clk_en  = r_clk_en;

endmodule

// File: rtl/pll_div_model.sv
// Lock sequencer plus NUM_CH divider channels driven from one reference clock.
// Optional macro PLL_DIV_PHASE_EN enables per-channel phase offsets.
module pll_div_model
  import pll_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int LOCK_CYCLES = 64
) (
  input logic             clk,
  input logic             rst_n,
  pll_div_model_if.slave  bus
);

  localparam int             LCW       = lock_cnt_w(LOCK_CYCLES);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_CYCLES);
  localparam logic [LCW-1:0] LCNT_ONE  = 1;

  state_e          r_state;
  state_e          w_state_next;
  logic [LCW-1:0]  r_lock_cnt;
  logic [LCW-1:0]  w_lock_cnt_next;
  logic            w_start;
  logic            w_run;
  logic            w_clear;
  logic [NUM_CH-1:0] w_clk_out;
  logic [NUM_CH-1:0] w_clk_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lock_cnt <= w_lock_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_lock_cnt_next = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        w_state_next    = ST_LOCKING;
        w_lock_cnt_next = '0;
      end
      ST_LOCKING: begin
        if (bus.cfg_load) begin
          w_lock_cnt_next = '0;
        end else begin
          if (r_lock_cnt != LOCK_MAX) w_lock_cnt_next = r_lock_cnt + LCNT_ONE;
          if (r_lock_cnt == LOCK_LAST) w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (bus.cfg_load) begin
          w_state_next    = ST_LOCKING;
          w_lock_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_lock_cnt_next = '0;
      end
    endcase
    // Dropping en overrides everything, including a simultaneous cfg_load.
    if (!bus.en) begin
      w_state_next    = ST_IDLE;
      w_lock_cnt_next = '0;
    end
  end

  // Channel controls track the state being entered, so outputs are valid the cycle locked reads 1.
  assign w_start = (r_state == ST_LOCKING) && (w_state_next == ST_LOCKED);
  assign w_run   = (r_state == ST_LOCKED)  && (w_state_next == ST_LOCKED);
  assign w_clear = !(w_start || w_run);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pll_div_chan #(.DIV_W(DIV_W)) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cfg_load  (bus.cfg_load),
      .i_cfg_div   (bus.cfg_div[i*DIV_W +: DIV_W]),
      .i_cfg_phase (bus.cfg_phase[i*DIV_W +: DIV_W]),
      .i_start     (w_start),
      .i_run       (w_run),
      .i_clear     (w_clear),
      .o_clk_out   (w_clk_out[i]),
      .o_clk_en    (w_clk_en[i])
    );
  end

  assign bus.clk_out = w_clk_out;
  assign bus.clk_en  = w_clk_en;
  assign bus.locked  = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_pll_div_model.sv
// Self-checking bench for pll_div_model: config table, hand sequences and random configs
// against a cycle-index arithmetic model of each divided channel.
module tb_pll_div_model;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 64;
`ifdef PLL_DIV_PHASE_EN
  localparam bit PH_ON = 1'b1;
`else
  localparam bit PH_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] div;
    logic [31:0] phase;
    int          first_en3;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   m_div   [NUM_CH];
  int   m_phase [NUM_CH];
  vec_t tbl     [4];

  pll_div_model_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  pll_div_model #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Channel behaviour as a function of cycles since locked rose: {clk_out, clk_en}.
  function automatic logic [1:0] chan_model(input int t, input int d, input int p);
    int de, pe, c;
    de = (d == 0) ? 1 : d;
    pe = PH_ON ? ((p > de - 1) ? de - 1 : p) : 0;
    c  = (t + de - pe) % de;
    return {(c < (de + 1) / 2), (c == 0)};
  endfunction

  task automatic apply_cfg(input logic [31:0] div, input logic [31:0] phase);
    bus.cfg_div   = div;
    bus.cfg_phase = phase;
    bus.cfg_load  = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]   = int'(div[i*DIV_W +: DIV_W]);
      m_phase[i] = int'(phase[i*DIV_W +: DIV_W]);
    end
    tick();
    bus.cfg_load = 1'b0;
  endtask

  // Called on the sample right after the edge that entered LOCKING.
  task automatic expect_lock(input string name);
    for (int k = 0; k < LOCK_CYCLES; k++) begin
      check({name, " hold"}, 32'({bus.locked, bus.clk_out, bus.clk_en}), 32'd0);
      tick();
    end
    check({name, " locked"}, 32'(bus.locked), 32'd1);
  endtask

  // Called on the first sample with locked=1.
  task automatic run_model(input string name, input int ncyc, output int first_en3);
    logic [NUM_CH-1:0] exp_out, exp_en;
    logic [1:0]        r;
    first_en3 = -1;
    for (int t = 0; t < ncyc; t++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r          = chan_model(t, m_div[i], m_phase[i]);
        exp_out[i] = r[1];
        exp_en[i]  = r[0];
      end
      check({name, " locked"},  32'(bus.locked),  32'd1);
      check({name, " clk_out"}, 32'(bus.clk_out), 32'(exp_out));
      check({name, " clk_en"},  32'(bus.clk_en),  32'(exp_en));
      if (first_en3 < 0 && bus.clk_en[3]) first_en3 = t;
      tick();
    end
  endtask

  initial begin
    int          first;
    logic [31:0] rdiv, rph;
    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{32'h08030201, 32'h00000000, 0};
    tbl[1] = '{32'h08040201, 32'h03000000, PH_ON ? 3 : 0};
    tbl[2] = '{32'h08070605, 32'h14090201, PH_ON ? 7 : 0};
    tbl[3] = '{32'h0910FF00, 32'h04000000, PH_ON ? 4 : 0};

    // Reset state
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.cfg_load  = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_phase = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]   = 1;
      m_phase[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("reset locked",  32'(bus.locked),  32'd0);
    check("reset clk_out", 32'(bus.clk_out), 32'd0);
    check("reset clk_en",  32'(bus.clk_en),  32'd0);

    // Lock from reset release with default div=1
    rst_n = 1'b1;
    tick();
    expect_lock("t1");
    run_model("t1 div1", 6, first);
    check("t1 first_en3", 32'(first), 32'd0);

    // Config table: each load relocks, then checked against the model
    for (int v = 0; v < 4; v++) begin
      apply_cfg(tbl[v].div, tbl[v].phase);
      expect_lock($sformatf("tbl%0d", v));
      run_model($sformatf("tbl%0d run", v), 40, first);
      check($sformatf("tbl%0d first_en3", v), 32'(first), 32'(tbl[v].first_en3));
    end

    // en=0 together with cfg_load: IDLE wins, new cfg used on next lock
    bus.en = 1'b0;
    apply_cfg(32'h0C060503, 32'h02020202);
    check("t5 idle", 32'({bus.locked, bus.clk_out, bus.clk_en}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5 idle hold", 32'({bus.locked, bus.clk_out, bus.clk_en}), 32'd0);
    end
    bus.en = 1'b1;
    tick();
    expect_lock("t5");
    run_model("t5 run", 30, first);

    // Random configurations
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rdiv[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 20));
        rph [i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 25));
      end
      apply_cfg(rdiv, rph);
      expect_lock($sformatf("rnd%0d", n));
      run_model($sformatf("rnd%0d run", n), 50, first);
    end

    // Async reset mid-LOCKED: immediate clear, cfg reverts to div=1
    apply_cfg(32'h04040404, 32'h01010101);
    expect_lock("t6 pre");
    run_model("t6 pre run", 5, first);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async", 32'({bus.locked, bus.clk_out, bus.clk_en}), 32'd0);
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]   = 1;
      m_phase[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_lock("t6");
    run_model("t6 div1", 8, first);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
